// File: rtl/mem_pkg.sv
// Shared constants and types for the main-memory model behind the data cache.
package mem_pkg;

    localparam int LINE_W  = 256;   // line width in bits
    localparam int DEPTH   = 512;   // number of lines
    localparam int ADDR_W  = 32;    // byte-address width
    localparam int LATENCY = 10;    // request acceptance to ack, in cycles (>= 2)

    // Line index slice of the byte address (32-byte lines, 16 KB total).
    localparam int IDX_LSB = 5;
    localparam int IDX_MSB = 13;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mem_pkg

// File: rtl/mem_latency_ctr.sv
// Access-latency counter: cleared when a request is accepted, counts while busy,
// and flags the edge on which the access must complete.
module mem_latency_ctr #(
    parameter int LATENCY = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    // Completion happens at the edge where the count reads LATENCY-2: the
    // acceptance edge plus LATENCY-1 busy edges.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(LATENCY - 2);

    logic [CNT_W-1:0] count_r;

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Terminal flag decoded from the current count.
    always_comb begin
        terminal = (count_r == TERM);
    end

endmodule : mem_latency_ctr

// File: rtl/data_memory.sv
// Main-memory model: 512 lines of 256 bits, whole-line read/write with a fixed
// latency and a one-cycle ack. Storage is not reset so preloaded data survives.
module data_memory #(
    parameter int LATENCY = mem_pkg::LATENCY,
    parameter int DEPTH   = mem_pkg::DEPTH,
    parameter int LINE_W  = mem_pkg::LINE_W,
    parameter int ADDR_W  = mem_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    import mem_pkg::*;

    logic [LINE_W-1:0] memory [DEPTH];

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic [LINE_W-1:0]  data_r;
    logic               write_r;

    logic               accept_s;
    logic               finish_s;
    logic               ctr_clear_s;
    logic               ctr_inc_s;
    logic               terminal_s;

    // Bits outside the line index are deliberately ignored (line offset and wrap).
    logic               unused_addr_bits_s;
    assign unused_addr_bits_s = ^{addr_i[ADDR_W-1:IDX_MSB+1], addr_i[IDX_LSB-1:0]};

    mem_latency_ctr #(
        .LATENCY (LATENCY)
    ) u_ctr (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (ctr_clear_s),
        .inc      (ctr_inc_s),
        .terminal (terminal_s)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        ctr_clear_s  = 1'b0;
        ctr_inc_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable_i) begin
                    accept_s     = 1'b1;
                    ctr_clear_s  = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                ctr_inc_s = 1'b1;
                if (terminal_s) begin
                    finish_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Request latch: inputs are captured once at acceptance and then ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_r   <= {IDX_W{1'b0}};
            data_r  <= {LINE_W{1'b0}};
            write_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= addr_i[IDX_MSB:IDX_LSB];
            data_r  <= data_i;
            write_r <= write_i;
        end else begin
            idx_r   <= idx_r;
            data_r  <= data_r;
            write_r <= write_r;
        end
    end

    // Ack pulse and read data; data_o holds until the next read completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o  <= 1'b0;
            data_o <= {LINE_W{1'b0}};
        end else begin
            ack_o <= finish_s;
            if (finish_s && !write_r) begin
                data_o <= memory[idx_r];
            end else begin
                data_o <= data_o;
            end
        end
    end

    // Write commit at the completion edge; storage itself has no reset.
    always_ff @(posedge clk_i) begin
        if (finish_s && write_r) begin
            memory[idx_r] <= data_r;
        end
    end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Bench for data_memory: timestamp-based reference model plus directed requests.
module tb_data_memory;

    import mem_pkg::*;

    logic              clk_i;
    logic              rst_i;
    logic [31:0]       addr_i;
    logic [255:0]      data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [255:0]      data_o;

    int errors = 0;
    int checks = 0;

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a request seen at edge c completes at edge c+LATENCY-1
    // (ack visible LATENCY cycles after the request cycle); the edge right after
    // completion is the DONE cycle, so the next request is taken at c_done+2 at earliest.
    logic [255:0] ref_mem [512];
    logic [255:0] exp_data;
    logic         exp_ack;
    int           cyc = 0;
    bit           m_busy = 0;
    bit           m_have = 0;
    int           m_done_at = 0;
    int           m_free_at = 0;
    int           m_idx = 0;
    logic [255:0] m_data;
    logic         m_wr;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy    = 0;
            m_free_at = 0;
            exp_ack   = 1'b0;
            exp_data  = 256'h0;
        end else begin
            cyc++;
            exp_ack = 1'b0;
            if (m_busy && cyc == m_done_at) begin
                if (m_wr) ref_mem[m_idx] = m_data;
                else      exp_data = ref_mem[m_idx];
                exp_ack   = 1'b1;
                m_busy    = 0;
                m_free_at = cyc + 2;
            end else if (!m_busy && cyc >= m_free_at && enable_i === 1'b1) begin
                m_busy    = 1;
                m_have    = 1;
                m_idx     = int'((addr_i % 32'd16384) / 32'd32);
                m_data    = data_i;
                m_wr      = write_i;
                m_done_at = cyc + LATENCY - 1;
            end
        end
    end

    // Compare process: outputs and the most recently addressed line, every cycle.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("ack", {255'h0, ack_o}, {255'h0, exp_ack});
            chk("data_o", data_o, exp_data);
            if (m_have) chk("mem_line", dut.memory[m_idx], ref_mem[m_idx]);
        end
    end

    task automatic preload(input int idx, input logic [255:0] v);
        dut.memory[idx] = v;
        ref_mem[idx]    = v;
    endtask

    // One request; enable drops and the other inputs are scrambled after one cycle.
    task automatic issue(input logic [31:0] a, input logic [255:0] d, input logic w, output int lat);
        int n;
        n   = 0;
        lat = -1;
        @(negedge clk_i);
        addr_i = a; data_i = d; write_i = w; enable_i = 1'b1;
        while (n < 40) begin
            @(negedge clk_i);
            n++;
            if (n == 1) begin
                enable_i = 1'b0; addr_i = ~a; data_i = ~d; write_i = ~w;
            end
            if (ack_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got none expected ack within 40 cycles");
        end
    endtask

    initial begin
        int lat, n, t1, t2;
        logic [255:0] beef;
        beef = {8{32'hDEADBEEF}};
        rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = 32'h0; data_i = 256'h0;
        preload(0, 256'h5);
        preload(1, 256'h11);
        preload(2, 256'h22);
        preload(3, 256'h33);
        preload(4, 256'h44);
        preload(32, 256'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_ack", {255'h0, ack_o}, 256'h0);
        chk("rst_data", data_o, 256'h0);

        // Plain read of line 0.
        issue(32'h0000_0000, 256'h0, 1'b0, lat);
        chk("read_lat", lat, 256'd10);
        chk("read_data", data_o, 256'h5);
        @(negedge clk_i);
        chk("ack_one_cycle", {255'h0, ack_o}, 256'h0);

        // Asynchronous reset mid-cycle: outputs clear at once, storage retained.
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_ack", {255'h0, ack_o}, 256'h0);
        chk("async_rst_data", data_o, 256'h0);
        chk("rst_mem_kept", dut.memory[0], 256'h5);
        chk("rst_state", {254'h0, dut.state_r}, {254'h0, IDLE});
        @(negedge clk_i);
        rst_i = 1'b0;

        // Write then read back line 32.
        issue(32'h0000_0400, beef, 1'b1, lat);
        chk("write_lat", lat, 256'd10);
        chk("write_mem", dut.memory[32], beef);
        chk("write_keeps_data_o", data_o, 256'h0);
        issue(32'h0000_0400, 256'h0, 1'b0, lat);
        chk("readback", data_o, beef);

        // Byte offset and 16 KB wrap.
        issue(32'h0000_001F, 256'h0, 1'b0, lat);
        chk("offset_read", data_o, 256'h5);
        issue(32'h0000_4020, 256'h0, 1'b0, lat);
        chk("alias_read", data_o, 256'h11);
        chk("alias_lat", lat, 256'd10);

        // Address change while busy is ignored (issue scrambles addr to ~a).
        issue(32'h0000_0040, 256'h0, 1'b0, lat);
        chk("latched_addr", data_o, 256'h22);

        // Enable held through ack: back-to-back request, 11 cycles apart.
        @(negedge clk_i);
        addr_i = 32'h0000_0080; write_i = 1'b0; enable_i = 1'b1;
        n = 0; t1 = -1; t2 = -1;
        while (n < 60 && t2 < 0) begin
            @(negedge clk_i);
            n++;
            if (ack_o === 1'b1) begin
                if (t1 < 0) t1 = n;
                else        t2 = n;
            end
            if (t1 >= 0 && n == t1 + 2) enable_i = 1'b0;
        end
        enable_i = 1'b0;
        chk("hold_first_lat", t1, 256'd10);
        chk("hold_gap", t2 - t1, 256'd11);
        chk("hold_data", data_o, 256'h44);

        // Reset during a busy write: no ack, line untouched, FSM idle.
        @(negedge clk_i);
        addr_i = 32'h0000_0060; data_i = {8{32'hCAFEF00D}}; write_i = 1'b1; enable_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            if (k == 1) enable_i = 1'b0;
        end
        #2 rst_i = 1'b1;
        #1;
        chk("abort_ack", {255'h0, ack_o}, 256'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (15) @(negedge clk_i);
        chk("abort_mem", dut.memory[3], 256'h33);
        chk("abort_state", {254'h0, dut.state_r}, {254'h0, IDLE});

        @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_data_memory
